i2c_seq_timer: RTL and testbench

//  Parametrised count-down sequencer timer for the I2C master control unit. Counts Ack strobes

---
 rtl/i2c_seq_timer_pkg.sv | 21 ++
 rtl/i2c_seq_timer_prescaler.sv | 43 ++++
 rtl/i2c_seq_timer.sv | 154 +++++++++++++++
 tb/tb_i2c_seq_timer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/i2c_seq_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_seq_timer_pkg
//  Purpose  : Shared constants for the I2C sequencer timer: FSM state
//             encodings and Mode bit positions.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package i2c_seq_timer_pkg;

    // FSM state encodings
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    // Mode bit indices
    localparam int c_mode_tick   = 1;   // 1: count prescaled ticks, 0: count Ack
    localparam int c_mode_reload = 0;   // 1: auto-reload, 0: one-shot

endpackage : i2c_seq_timer_pkg
`default_nettype wire

// File: rtl/i2c_seq_timer_prescaler.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_tick_prescaler
//  Purpose  : Free-running tick divider. While enabled it counts 0..Presc and
//             asserts Tick for one clock when the count equals Presc, then
//             returns to 0. A clear or de-assertion of En resets the count.
//  Ports    : Clk   in   clock, rising edge
//             Rst   in   synchronous active-high reset
//             Clr   in   synchronous clear of the divider count
//             En    in   count enable
//             Presc in   divide value (tick every Presc+1 clocks)
//             Tick  out  one-clock tick strobe
//  Revision : 1.0  initial release
// ============================================================================
module i2c_tick_prescaler #(
    parameter int PRESC_W = 8
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Clr,
    input  logic               En,
    input  logic [PRESC_W-1:0] Presc,
    output logic               Tick
);

    logic [PRESC_W-1:0] r_count;
    logic               w_wrap;

    assign w_wrap = (r_count == Presc);
    assign Tick   = En && w_wrap;

    always_ff @(posedge Clk) begin
        if (Rst || Clr) begin
            r_count <= '0;
        end else if (En) begin
            r_count <= w_wrap ? '0 : r_count + PRESC_W'(1);
        end else begin
            r_count <= '0;
        end
    end

endmodule : i2c_tick_prescaler
`default_nettype wire

// File: rtl/i2c_seq_timer.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_seq_timer
//  Purpose  : Count-down sequencer timer for the I2C byte-level controller.
//             Counts Ack strobes or prescaled ticks from a loaded start value,
//             in one-shot or auto-reload mode, with a registered Done pulse
//             and a sticky overrun flag.
//  Ports    : Clk      in   clock, rising edge
//             Rst      in   synchronous active-high reset
//             Load     in   latch LoadVal/Mode/Presc and (re)start
//             LoadVal  in   start value (events until Done)
//             Mode     in   [1] tick/Ack source, [0] reload/one-shot
//             Presc    in   tick every Presc+1 clocks (tick mode)
//             Ack      in   decrement strobe (Ack mode)
//             Abort    in   stop immediately, no Done
//             Cnt      out  current count
//             Zero     out  Cnt == 0
//             Done     out  one-clock pulse after the terminal event
//             Busy     out  timer running
//             Ovr      out  sticky: event seen while not running
//  Revision : 1.0  initial release
// ============================================================================
module i2c_seq_timer
    import i2c_seq_timer_pkg::*;
#(
    parameter int SIZE    = 4,
    parameter int PRESC_W = 8
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Load,
    input  logic [SIZE-1:0]    LoadVal,
    input  logic [1:0]         Mode,
    input  logic [PRESC_W-1:0] Presc,
    input  logic               Ack,
    input  logic               Abort,
    output logic [SIZE-1:0]    Cnt,
    output logic               Zero,
    output logic               Done,
    output logic               Busy,
    output logic               Ovr
);

    logic [1:0]         r_state;
    logic [SIZE-1:0]    r_cnt;
    logic [SIZE-1:0]    r_load_val;
    logic [1:0]         r_mode;
    logic [PRESC_W-1:0] r_presc;
    logic               r_done;
    logic               r_ovr;

    logic [1:0]         w_state_nxt;
    logic [SIZE-1:0]    w_cnt_nxt;
    logic               w_done_nxt;
    logic               w_ovr_nxt;
    logic               w_run;
    logic               w_tick;
    logic               w_ev;
    logic               w_presc_en;
    logic               w_presc_clr;

    assign w_run = (r_state == c_st_run);

    // The divider only runs while counting ticks; a Load or Abort in the same
    // cycle restarts it so the first tick lands Presc+1 clocks after Load.
    assign w_presc_en  = w_run && r_mode[c_mode_tick] && !Load && !Abort;
    assign w_presc_clr = Load || Abort || !w_run;

    i2c_tick_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .Clk   (Clk),
        .Rst   (Rst),
        .Clr   (w_presc_clr),
        .En    (w_presc_en),
        .Presc (r_presc),
        .Tick  (w_tick)
    );

    // In tick mode Ack is ignored entirely, including for overrun detection.
    assign w_ev = r_mode[c_mode_tick] ? w_tick : Ack;

    // Next-state / next-count logic. Priority: Abort > Load > event.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        w_ovr_nxt   = r_ovr;

        if (Abort) begin
            w_state_nxt = c_st_idle;
            w_cnt_nxt   = '0;
            w_ovr_nxt   = 1'b0;
        end else if (Load) begin
            w_ovr_nxt = 1'b0;
            if (LoadVal != '0) begin
                w_state_nxt = c_st_run;
                w_cnt_nxt   = LoadVal;
            end else begin
                // Zero-length run terminates immediately.
                w_state_nxt = c_st_done;
                w_cnt_nxt   = '0;
                w_done_nxt  = 1'b1;
            end
        end else if (w_ev) begin
            if (w_run) begin
                if (r_cnt > SIZE'(1)) begin
                    w_cnt_nxt = r_cnt - SIZE'(1);
                end else if (r_cnt == SIZE'(1)) begin
                    w_done_nxt = 1'b1;
                    if (r_mode[c_mode_reload]) begin
                        w_cnt_nxt = r_load_val;
                    end else begin
                        w_state_nxt = c_st_done;
                        w_cnt_nxt   = '0;
                    end
                end
                // r_cnt == 0 while running cannot occur; hold rather than wrap.
            end else begin
                w_ovr_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state    <= c_st_idle;
            r_cnt      <= '0;
            r_load_val <= '0;
            r_mode     <= '0;
            r_presc    <= '0;
            r_done     <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
            r_ovr   <= w_ovr_nxt;
            if (Load && !Abort) begin
                r_load_val <= LoadVal;
                r_mode     <= Mode;
                r_presc    <= Presc;
            end
        end
    end

    assign Cnt  = r_cnt;
    assign Zero = (r_cnt == '0);
    assign Done = r_done;
    assign Busy = w_run;
    assign Ovr  = r_ovr;

endmodule : i2c_seq_timer
`default_nettype wire

// File: tb/tb_i2c_seq_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_seq_timer
//  Purpose  : Self-checking bench for i2c_seq_timer. Each stimulus cycle
//             pushes the outputs expected after the next rising edge onto a
//             scoreboard; a monitor pops and compares them after that edge.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_i2c_seq_timer;

    localparam int SIZE    = 4;
    localparam int PRESC_W = 8;

    logic               Clk;
    logic               Rst;
    logic               Load;
    logic [SIZE-1:0]    LoadVal;
    logic [1:0]         Mode;
    logic [PRESC_W-1:0] Presc;
    logic               Ack;
    logic               Abort;
    logic [SIZE-1:0]    Cnt;
    logic               Zero;
    logic               Done;
    logic               Busy;
    logic               Ovr;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string           name;
        logic [SIZE-1:0] cnt;
        logic            done;
        logic            busy;
        logic            ovr;
    } exp_t;

    exp_t sb[$];

    i2c_seq_timer #(
        .SIZE    (SIZE),
        .PRESC_W (PRESC_W)
    ) u_dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .Load    (Load),
        .LoadVal (LoadVal),
        .Mode    (Mode),
        .Presc   (Presc),
        .Ack     (Ack),
        .Abort   (Abort),
        .Cnt     (Cnt),
        .Zero    (Zero),
        .Done    (Done),
        .Busy    (Busy),
        .Ovr     (Ovr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: compare outputs shortly after each rising edge.
    always @(posedge Clk) begin
        exp_t e;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check_val({e.name, ".cnt"},  32'(Cnt),  32'(e.cnt));
            check_val({e.name, ".zero"}, 32'(Zero), 32'(e.cnt == '0));
            check_val({e.name, ".done"}, 32'(Done), 32'(e.done));
            check_val({e.name, ".busy"}, 32'(Busy), 32'(e.busy));
            check_val({e.name, ".ovr"},  32'(Ovr),  32'(e.ovr));
        end
    end

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic step(input string name,
                        input logic rst, input logic abort, input logic load,
                        input logic [SIZE-1:0] lv, input logic [1:0] mode,
                        input logic [PRESC_W-1:0] presc, input logic ack,
                        input logic [SIZE-1:0] e_cnt, input logic e_done,
                        input logic e_busy, input logic e_ovr);
        exp_t e;
        @(negedge Clk);
        Rst     = rst;
        Abort   = abort;
        Load    = load;
        LoadVal = lv;
        Mode    = mode;
        Presc   = presc;
        Ack     = ack;
        e.name  = name;
        e.cnt   = e_cnt;
        e.done  = e_done;
        e.busy  = e_busy;
        e.ovr   = e_ovr;
        sb.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        Rst = 1'b1; Abort = 1'b0; Load = 1'b0; LoadVal = '0;
        Mode = '0; Presc = '0; Ack = 1'b0;

        // Reset state
        step("rst0", 1,0,0, 0,2'b00,0,0,  0,0,0,0);
        step("rst1", 1,0,0, 0,2'b00,0,0,  0,0,0,0);

        // 1. One-shot Ack count from 8
        step("t1.load", 0,0,1, 8,2'b00,0,0, 8,0,1,0);
        for (int i = 1; i <= 7; i++)
            step($sformatf("t1.ack%0d", i), 0,0,0, 0,2'b00,0,1, 4'(8-i),0,1,0);
        step("t1.ack8", 0,0,0, 0,2'b00,0,1, 0,1,0,0);
        step("t1.idle", 0,0,0, 0,2'b00,0,0, 0,0,0,0);

        // 4. Boundaries: event in DONE, Load of zero
        step("t4.ackdone", 0,0,0, 0,2'b00,0,1, 0,0,0,1);
        step("t4.hold",    0,0,0, 0,2'b00,0,0, 0,0,0,1);
        step("t4.load0",   0,0,1, 0,2'b00,0,0, 0,1,0,0);
        step("t4.after0",  0,0,0, 0,2'b00,0,0, 0,0,0,0);

        // 2. Auto-reload from 3, seven Acks
        step("t2.load", 0,0,1, 3,2'b01,0,0, 3,0,1,0);
        step("t2.ack1", 0,0,0, 0,2'b00,0,1, 2,0,1,0);
        step("t2.ack2", 0,0,0, 0,2'b00,0,1, 1,0,1,0);
        step("t2.ack3", 0,0,0, 0,2'b00,0,1, 3,1,1,0);
        step("t2.ack4", 0,0,0, 0,2'b00,0,1, 2,0,1,0);
        step("t2.ack5", 0,0,0, 0,2'b00,0,1, 1,0,1,0);
        step("t2.ack6", 0,0,0, 0,2'b00,0,1, 3,1,1,0);
        step("t2.ack7", 0,0,0, 0,2'b00,0,1, 2,0,1,0);

        // Reload with period 1: Done on consecutive cycles
        step("t2.load1", 0,0,1, 1,2'b01,0,0, 1,0,1,0);
        step("t2.r1a",   0,0,0, 0,2'b00,0,1, 1,1,1,0);
        step("t2.r1b",   0,0,0, 0,2'b00,0,1, 1,1,1,0);
        step("t2.abort", 0,1,0, 0,2'b00,0,0, 0,0,0,0);

        // 3. Tick mode, LoadVal=2, Presc=3; Acks held high and ignored
        step("t3.load", 0,0,1, 2,2'b10,3,1, 2,0,1,0);
        for (int i = 1; i <= 3; i++)
            step($sformatf("t3.c%0d", i), 0,0,0, 0,2'b00,0,1, 2,0,1,0);
        for (int i = 4; i <= 7; i++)
            step($sformatf("t3.c%0d", i), 0,0,0, 0,2'b00,0,1, 1,0,1,0);
        step("t3.c8",   0,0,0, 0,2'b00,0,1, 0,1,0,0);
        step("t3.c9",   0,0,0, 0,2'b00,0,1, 0,0,0,0);

        // Tick mode, Presc=0, reload: tick every clock
        step("t3.p0load", 0,0,1, 2,2'b11,0,0, 2,0,1,0);
        step("t3.p0c1",   0,0,0, 0,2'b00,0,0, 1,0,1,0);
        step("t3.p0c2",   0,0,0, 0,2'b00,0,0, 2,1,1,0);
        step("t3.p0c3",   0,0,0, 0,2'b00,0,0, 1,0,1,0);
        step("t3.abort",  0,1,0, 0,2'b00,0,0, 0,0,0,0);

        // 5. Collisions
        step("t5.load",      0,0,1, 5,2'b00,0,0, 5,0,1,0);
        step("t5.ack",       0,0,0, 0,2'b00,0,1, 4,0,1,0);
        step("t5.loadack",   0,0,1, 9,2'b00,0,1, 9,0,1,0);
        step("t5.ack2",      0,0,0, 0,2'b00,0,1, 8,0,1,0);
        step("t5.abortload", 0,1,1, 6,2'b00,0,0, 0,0,0,0);
        step("t5.idle",      0,0,0, 0,2'b00,0,0, 0,0,0,0);

        // 6. Reset mid-count from tick mode; ModeReg returns to Ack mode
        step("t6.load",  0,0,1, 6,2'b10,0,0, 6,0,1,0);
        step("t6.tick",  0,0,0, 0,2'b00,0,0, 5,0,1,0);
        step("t6.rst",   1,0,0, 0,2'b00,0,1, 0,0,0,0);
        step("t6.ack",   0,0,0, 0,2'b00,0,1, 0,0,0,1);
        step("t6.hold",  0,0,0, 0,2'b00,0,0, 0,0,0,1);
        step("t6.abort", 0,1,0, 0,2'b00,0,0, 0,0,0,0);

        @(negedge Clk);
        Abort = 1'b0;
        repeat (3) @(posedge Clk);
        #2;
        if (sb.size() != 0)
            check_val("sb.drain", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_i2c_seq_timer
`default_nettype wire
